// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with a registered one-hot grant.
// A winner keeps the grant for eff_weight accepted beats while it keeps requesting;
// then the priority pointer moves past it and the next winner is granted without a bubble.
// Optional feature: define WRR_ARBITER_LOCK_EN to add the lock input, which pins the
// grant on the current owner without spending credit.
module wrr_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
  input  logic                          gnt_ready,
`ifdef WRR_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [IdW-1:0]        cur_q, cur_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IdW-1:0]        gnt_id_q, gnt_id_d;
  logic                  gnt_valid_q, gnt_valid_d;

  logic [WEIGHT_W-1:0]   weight_arr [NUM_REQ];
  logic [IdW-1:0]        ptr_nxt;
  logic [IdW-1:0]        search_base;
  logic [IdW-1:0]        win_id;
  logic                  win_found;
  logic [WEIGHT_W-1:0]   win_weight;
  logic [WEIGHT_W-1:0]   fresh_credit;
  logic                  lock_hold;
  logic                  load;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_weight
    assign weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
  end

`ifdef WRR_ARBITER_LOCK_EN
  assign lock_hold = lock[cur_q] & req[cur_q];
`else
  assign lock_hold = 1'b0;
`endif

  // Pointer after the current owner's turn, wrapping at NUM_REQ-1.
  assign ptr_nxt     = (32'(cur_q) == NUM_REQ - 1) ? '0 : cur_q + 1'b1;
  // In GRANT the only search that matters is the end-of-turn one from ptr_nxt.
  assign search_base = (state_q == StIdle) ? ptr_q : ptr_nxt;

  // First asserted request at or after search_base, wrapping upward.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(search_base) + k) % NUM_REQ;
      if (!win_found && req[IdW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IdW'(idx);
      end
    end
  end

  // Fresh credit for the winner: a zero weight behaves as one beat.
  assign win_weight   = weight_arr[win_id];
  assign fresh_credit = (win_weight == '0) ? '0 : win_weight - 1'b1;

  // Next-state logic for the FSM, pointer, credit and registered grant outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    credit_d    = credit_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    load        = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) load = 1'b1;
      end
      StGrant: begin
        if (gnt_ready) begin
          if (lock_hold) begin
            // Locked owner keeps the grant; credit is frozen.
          end else if (credit_q != '0 && req[cur_q]) begin
            credit_d = credit_q - 1'b1;
          end else begin
            ptr_d = ptr_nxt;
            if (win_found) begin
              load = 1'b1;
            end else begin
              state_d     = StIdle;
              gnt_d       = '0;
              gnt_id_d    = '0;
              gnt_valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d     = StGrant;
      cur_d       = win_id;
      gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
      gnt_id_d    = win_id;
      gnt_valid_d = 1'b1;
      credit_d    = fresh_credit;
    end
  end

  // State registers; reset drops any remaining burst credit and restarts at ptr 0.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_q       <= '0;
      credit_q    <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      credit_q    <= credit_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, giving the number of requestors (2..32).
REQ-002 The block SHALL have parameter WEIGHT_W, default 4, giving the width of each per-requestor weight field.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  request vector; bit i is requestor i.
REQ-006 weight  input  NUM_REQ*WEIGHT_W  beats per turn; field i is bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static.
REQ-007 gnt_ready  input  1  downstream accepts the current grant beat.
REQ-008 gnt  output  NUM_REQ  registered one-hot grant; all zero when gnt_valid=0.
REQ-009 gnt_valid  output  1  a grant is presented.
REQ-010 gnt_id  output  $clog2(NUM_REQ)  binary index of the granted requestor; 0 when idle.

Function
REQ-011 The block SHALL contain a priority pointer ptr, a credit counter (WEIGHT_W bits), a current-owner register cur, and a two-state FSM: IDLE, GRANT.
REQ-012 Winner selection SHALL be the first asserted req bit at or after ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-013 IDLE: gnt_valid=0; if any req bit is set, the next cycle SHALL enter GRANT with cur=winner, gnt=onehot(winner), gnt_id=winner, credit=eff_weight(winner)-1 (request-to-grant latency exactly 1 cycle).
REQ-014 eff_weight(i) SHALL be weight field i, with 0 treated as 1.
REQ-015 GRANT with gnt_ready=0: gnt, gnt_id, credit, ptr and the FSM state SHALL hold unchanged, regardless of req.
REQ-016 GRANT with gnt_ready=1 (accepted beat), credit!=0 and req[cur]=1: the block SHALL stay on cur and decrement credit by 1.
REQ-017 Accepted beat otherwise (credit==0 or req[cur]=0): ptr SHALL become (cur+1) mod NUM_REQ. The winner is re-searched in the same cycle from the new ptr using the current req.
REQ-018 If a winner exists in the REQ-017 case, the block SHALL grant it in the next cycle with no idle bubble and a fresh credit, and cur SHALL win again only if it is the sole requestor. If no winner exists, the FSM SHALL return to IDLE.
REQ-019 gnt SHALL always be one-hot or zero, and gnt_id SHALL always equal the encoded gnt.
REQ-020 A weight change SHALL take effect only at the next load of the credit counter.
REQ-021 The credit counter SHALL never underflow or wrap.

Reset
REQ-022 On rst_b=0, asynchronously: gnt=0, gnt_valid=0, gnt_id=0, ptr=0, cur=0, credit=0, FSM=IDLE.
REQ-023 A reset asserted mid-burst SHALL discard the remaining credit. After release, arbitration SHALL restart from ptr=0.

Configuration
REQ-024 Macro WRR_ARBITER_LOCK_EN SHALL add the input port lock (NUM_REQ bits).
REQ-025 With WRR_ARBITER_LOCK_EN defined, an accepted beat with lock[cur]=1 and req[cur]=1 SHALL keep the grant on cur without decrementing credit. Once lock[cur]=0, normal credit rules resume from the held credit value.
REQ-026 Without WRR_ARBITER_LOCK_EN, the lock port SHALL be absent and behaviour SHALL be exactly REQ-011..REQ-023.

Verification
REQ-027 NUM_REQ=4, all weights 1, req=4'b1111, gnt_ready=1 -> gnt_id sequence 0,1,2,3,0,1; gnt_valid continuously 1 after the first cycle.
REQ-028 NUM_REQ=4, weight0=3, weight1=1, req=4'b0011, gnt_ready=1 -> gnt_id 0,0,0,1,0,0,0,1.
REQ-029 Granted requestor 2 with gnt_ready=0 for 5 cycles -> gnt=4'b0100 and credit stable all 5 cycles; sequence resumes on the first gnt_ready=1.
REQ-030 weight2=4, req=4'b0110, req[2] dropped after its 2nd accepted beat -> gnt_id 2,2,1; ptr=3 after requestor 2's turn.
REQ-031 (WRR_ARBITER_LOCK_EN) weight1=1, lock[1]=1 for 6 accepted beats, req=4'b1011 -> gnt_id=1 for all 6 beats; after lock drops -> next grant 3.
REQ-032 rst_b pulsed low mid-burst on requestor 3 with req=4'b1111 -> outputs 0 in the same cycle; first grant after release is 0.
